// File: rtl/seq_shift_unit.sv
// Multi-cycle SLL/SRL/SRA shifter, STEP bits per cycle, with a start/busy/done handshake.
// Optional rotate-right on op=11 when SEQ_SHIFT_ROTATE_EN is defined; otherwise op=11 acts as SRL.
module seq_shift_unit #(
    parameter int STEP = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] opnd,
    input  logic [31:0] ext_shamt,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    if (!(STEP == 1 || STEP == 2 || STEP == 4 || STEP == 8 || STEP == 16)) begin : g_bad_step
        $error("seq_shift_unit: STEP must be 1, 2, 4, 8 or 16");
    end

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRL  = 2'b01;
    localparam logic [1:0] OP_SRA  = 2'b10;

    localparam logic [4:0] STEP_K  = 5'(STEP);

    logic [1:0]  state;
    logic [31:0] acc;
    logic [4:0]  rem;
    logic [1:0]  op_q;

    logic [4:0]  k;
    logic [4:0]  rem_nxt;
    logic [31:0] acc_shf;

    // Only the low five shift-amount bits are meaningful; the rest are absorbed here.
    logic unused_shamt_hi;
    assign unused_shamt_hi = ^ext_shamt[31:5];

    always_comb begin
        // NOTE: every signal gets a default first so no latch is inferred.
        k       = (rem < STEP_K) ? rem : STEP_K;
        rem_nxt = rem - k;
        acc_shf = acc >> k;
        case (op_q)
            OP_SLL:  acc_shf = acc << k;
            OP_SRL:  acc_shf = acc >> k;
            OP_SRA:  acc_shf = $unsigned($signed(acc) >>> k);
`ifdef SEQ_SHIFT_ROTATE_EN
            default: acc_shf = (acc >> k) | (acc << (6'd32 - {1'b0, k}));
`else
            default: acc_shf = acc >> k;
`endif
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (reset) begin
            state  <= S_IDLE;
            acc    <= '0;
            rem    <= '0;
            op_q   <= OP_SLL;
            result <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        acc  <= opnd;
                        rem  <= ext_shamt[4:0];
                        op_q <= op;
                        if (ext_shamt[4:0] == 5'd0) begin
                            state  <= S_DONE;
                            result <= opnd;
                        end else begin
                            state <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    acc <= acc_shf;
                    rem <= rem_nxt;
                    // result is captured on the edge that enters DONE and held afterwards.
                    if (rem_nxt == 5'd0) begin
                        state  <= S_DONE;
                        result <= acc_shf;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy = (state == S_SHIFT);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_seq_shift_unit.sv
// Bench for seq_shift_unit: STEP=1 and STEP=4 instances share stimulus and are compared every
// cycle against a transaction-level model (full-amount shift, latency = ceil(n/STEP)+1).
module tb_seq_shift_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] opnd;
    logic [31:0] ext_shamt;

    logic        busy1, done1, busy4, done4;
    logic [31:0] result1, result4;

    int n_checks = 0;
    int n_fail   = 0;

    int          m_left [2];
    bit          m_done [2];
    logic [31:0] m_res  [2];
    logic [31:0] m_pend [2];

    always #5 clk = ~clk;

    seq_shift_unit #(.STEP(1)) u_s1 (
        .clk(clk), .reset(reset), .start(start), .op(op), .opnd(opnd),
        .ext_shamt(ext_shamt), .busy(busy1), .done(done1), .result(result1)
    );

    seq_shift_unit #(.STEP(4)) u_s4 (
        .clk(clk), .reset(reset), .start(start), .op(op), .opnd(opnd),
        .ext_shamt(ext_shamt), .busy(busy4), .done(done4), .result(result4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [1:0] o, input logic [31:0] a, input int n);
        logic [31:0] r;
        case (o)
            2'b00:   r = a << n;
            2'b01:   r = a >> n;
            2'b10:   r = $unsigned($signed(a) >>> n);
`ifdef SEQ_SHIFT_ROTATE_EN
            default: r = (n == 0) ? a : ((a >> n) | (a << (32 - n)));
`else
            default: r = a >> n;
`endif
        endcase
        return r;
    endfunction

    function automatic int step_of(input int s);
        return (s == 0) ? 1 : 4;
    endfunction

    task automatic model_step(input int s);
        int n;
        if (reset) begin
            m_left[s] = 0;
            m_done[s] = 1'b0;
            m_res[s]  = '0;
        end else if (m_done[s]) begin
            m_done[s] = 1'b0;
        end else if (m_left[s] > 0) begin
            m_left[s]--;
            if (m_left[s] == 0) begin
                m_done[s] = 1'b1;
                m_res[s]  = m_pend[s];
            end
        end else if (start) begin
            n         = int'(ext_shamt[4:0]);
            m_pend[s] = ref_shift(op, opnd, n);
            m_left[s] = (n + step_of(s) - 1) / step_of(s);
            if (m_left[s] == 0) begin
                m_done[s] = 1'b1;
                m_res[s]  = m_pend[s];
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        check("busy_s1",   32'(busy1), 32'(m_left[0] != 0));
        check("done_s1",   32'(done1), 32'(m_done[0]));
        check("result_s1", result1,    m_res[0]);
        check("busy_s4",   32'(busy4), 32'(m_left[1] != 0));
        check("done_s4",   32'(done4), 32'(m_done[1]));
        check("result_s4", result4,    m_res[1]);
    endtask

    function automatic bit model_busy();
        return (m_left[0] != 0) || m_done[0] || (m_left[1] != 0) || m_done[1];
    endfunction

    task automatic wait_idle();
        for (int i = 0; i < 40 && model_busy(); i++) tick();
    endtask

    task automatic directed(input string tag, input logic [1:0] o, input logic [31:0] a,
                            input logic [31:0] sh, input logic [31:0] exp_res,
                            input int lat1, input int lat4);
        int got1 = 0;
        int got4 = 0;
        wait_idle();
        start = 1'b1; op = o; opnd = a; ext_shamt = sh;
        tick();
        start = 1'b0; op = 2'($urandom); opnd = $urandom; ext_shamt = $urandom;
        for (int c = 1; c <= 40 && (got1 == 0 || got4 == 0); c++) begin
            if (done1 && got1 == 0) begin
                got1 = c;
                check({tag, "_res_s1"}, result1, exp_res);
            end
            if (done4 && got4 == 0) begin
                got4 = c;
                check({tag, "_res_s4"}, result4, exp_res);
            end
            if (got1 == 0 || got4 == 0) tick();
        end
        check({tag, "_lat_s1"}, got1, lat1);
        check({tag, "_lat_s4"}, got4, lat4);
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; start = 1'b0; op = 2'b00; opnd = '0; ext_shamt = '0;
        m_left = '{0, 0}; m_done = '{1'b0, 1'b0}; m_res = '{32'h0, 32'h0}; m_pend = '{32'h0, 32'h0};
        tick();
        tick();
        check("reset_result_s1", result1, 32'h0);
        check("reset_busy_s4",   32'(busy4), 32'h0);
        reset = 1'b0;
        tick();

        directed("sll31",  2'b00, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 32, 9);
        directed("sra5",   2'b10, 32'h8000_0000, 32'h0000_0005, 32'hFC00_0000, 6, 3);
        directed("srl0",   2'b01, 32'hDEAD_BEEF, 32'hFFFF_FFE0, 32'hDEAD_BEEF, 1, 1);
`ifdef SEQ_SHIFT_ROTATE_EN
        directed("op11",   2'b11, 32'h0000_00F1, 32'h0000_0004, 32'h1000_000F, 5, 2);
`else
        directed("op11",   2'b11, 32'h0000_00F1, 32'h0000_0004, 32'h0000_000F, 5, 2);
`endif

        // Reset during the fourth SHIFT cycle of a STEP=1 SRL by 10.
        wait_idle();
        start = 1'b1; op = 2'b01; opnd = 32'hFFFF_FFFF; ext_shamt = 32'd10;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_busy",   32'(busy1), 32'h0);
        check("midrst_done",   32'(done1), 32'h0);
        check("midrst_result", result1,    32'h0);
        directed("after_rst", 2'b01, 32'hFFFF_FFFF, 32'd10, 32'h003F_FFFF, 11, 4);

        // Random single-cycle starts with random gaps and occasional resets.
        for (int i = 0; i < 120; i++) begin
            int gap;
            reset     = ($urandom_range(0, 19) == 0);
            start     = 1'b1;
            op        = 2'($urandom);
            opnd      = $urandom;
            ext_shamt = $urandom;
            tick();
            reset = 1'b0;
            start = 1'b0;
            gap   = $urandom_range(0, 12);
            for (int j = 0; j < gap; j++) tick();
        end

        // Start held high: only IDLE accepts; inputs change every cycle.
        wait_idle();
        start = 1'b1;
        for (int i = 0; i < 300; i++) begin
            op        = 2'($urandom);
            opnd      = $urandom;
            ext_shamt = $urandom;
            tick();
        end
        start = 1'b0;
        wait_idle();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
